inst_mem_server: RTL and testbench
==================================

Name: inst_mem_server

Overview:
- Responder end of the processor's instruction-fetch interface: accepts an address request from the core and returns the stored instruction word after a fixed, parameterised wait.
- Holds a small program store that a separate loader port fills while the store is idle.
- Sits between the processor fetch stage and the board-level program loader.

Parameters:
- DATA_W, 8: instruction word width.
- ADDR_W, 2: request/load address width.
- DEPTH, 4: number of stored words; must be at most 2**ADDR_W.
- WAIT_CYCLES, 2: wait states between request accept and response (0 allowed).
- NOP_WORD, 8'h00: word returned for an out-of-range address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  core presents a fetch address.
- req_addr  in  ADDR_W  fetch address.
- req_ready  out  1  store can accept a fetch this cycle.
- inst  out  DATA_W  returned instruction word.
- inst_valid  out  1  inst is valid; held until acknowledged.
- inst_err  out  1  qualifies inst: the address was out of range (>= DEPTH).
- inst_ack  in  1  core consumes the response.
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader write address.
- ld_data  in  DATA_W  loader write data.
- ld_ready  out  1  a load is accepted this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; inst=0; inst_valid=0; inst_err=0; wait counter=0; captured address=0.
  - All DEPTH store words cleared to 0.
  - Reset mid-transaction aborts it; no response is emitted after release.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = !ld_en. ld_ready = 1.
  - Load accept: ld_en=1 with ld_addr<DEPTH writes ld_data to the store at that cycle's edge. ld_addr>=DEPTH is silently dropped.
  - Request accept: req_valid && req_ready captures req_addr.
    - WAIT_CYCLES>0: go to WAIT with counter = WAIT_CYCLES-1.
    - WAIT_CYCLES=0: go to RESP directly.
- Simultaneous ld_en and req_valid in IDLE:
  - The load wins and req_ready=0, so the request is not accepted.
  - The core keeps req_valid high; the request is accepted on the first cycle with ld_en=0.
- WAIT:
  - req_ready=0; ld_ready=0; loads are ignored (no write).
  - The counter decrements each cycle; at 0 the FSM moves to RESP.
- Entry to RESP:
  - inst is registered from the store at the captured address.
  - If the address >= DEPTH, inst=NOP_WORD and inst_err=1.
  - inst_valid rises.
  - Latency: inst_valid is high exactly WAIT_CYCLES+1 cycles after the accept edge.
- RESP:
  - inst, inst_err and inst_valid are held stable until inst_ack=1.
  - inst_ack && inst_valid: inst_valid=0, inst_err=0 and the FSM returns to IDLE on that edge. inst keeps its last value.
  - inst_ack outside RESP is ignored.
  - req_ready=0 and ld_ready=0; back-to-back fetches therefore have at least one IDLE cycle between them.
- Address arithmetic is unsigned, with no wrap-around inside the block. The core owns address wrapping (3 -> 0 when DEPTH=4).
- Store reads are synchronous only, so no combinational path exists from req_addr to inst.

Decomposition:
- Shared package proc_pkg holds:
  - the FSM state enum {IDLE, WAIT, RESP};
  - the default NOP_WORD constant;
  - the shared DATA_W/ADDR_W defaults, so the processor and this block agree.
- One natural sub-module: fetch_wait_counter, a loadable down-counter with a done flag that drives the WAIT→RESP transition.
- The store array and the FSM stay in inst_mem_server.

Test Plan:
- Load and fetch: after reset, load addr0..3 = 8'hA1, B2, C3, D4; then fetch addr2 with WAIT_CYCLES=2 → inst_valid rises 3 cycles after accept with inst=8'hC3, inst_err=0.
- Held response: fetch addr1, keep inst_ack=0 for 5 cycles → inst=8'hB2 and inst_valid stay stable; req_ready=0 throughout; ack → IDLE next edge.
- Contention: in IDLE assert ld_en (addr3, 8'h5E) and req_valid (addr3) together → req_ready=0, write occurs; next cycle the request is accepted and returns 8'h5E.
- Out of range: DEPTH=3, ADDR_W=2, fetch addr3 → inst=NOP_WORD, inst_err=1. Also ld_en to addr3 during IDLE → no store word changes.
- Load blocked: ld_en to addr0 during WAIT → ld_ready=0 and a later fetch of addr0 returns the old 8'hA1. WAIT_CYCLES=0 → inst_valid is high 1 cycle after accept.
- Reset mid-WAIT: assert rst low during WAIT → all outputs 0 immediately (asynchronously); after release, no inst_valid appears and a fetch of addr0 returns 8'h00 (store cleared).

Source files
------------

// File: rtl/proc_pkg.sv
// Definitions shared between the processor fetch stage and its instruction store:
// fetch FSM states and the interface width/word defaults both sides agree on.
package proc_pkg;
  localparam int         DATA_W_DEF   = 8;
  localparam int         ADDR_W_DEF   = 2;
  localparam logic [7:0] NOP_WORD_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable down-counter that paces the wait states of a fetch; done is high
// whenever the count has reached zero.
module fetch_wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/inst_mem_server.sv
// Instruction-fetch responder: small loader-filled program store answering core
// fetches after a fixed number of wait states, response held until acknowledged.
module inst_mem_server
  import proc_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DEPTH       = 4,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              inst_err,
  input  logic              inst_ack,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready
);
  localparam int               CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              cnt_load, cnt_dec, cnt_done;
  logic              ld_accept;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  fetch_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid && req_ready) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt_done) state_nxt = RESP;
      RESP:    if (inst_valid && inst_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Readies are gated by reset so every output reads 0 while it is held
  always_comb begin
    req_ready = 1'b0;
    ld_ready  = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = rst && !ld_en;
        ld_ready  = rst;
        cnt_load  = req_valid && !ld_en;
      end
      WAIT:    cnt_dec = 1'b1;
      default: ;
    endcase
  end

  assign ld_accept = (state == IDLE) && ld_en && in_range(ld_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ld_accept) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    rd_word = NOP_WORD;
    if (in_range(cap_addr)) rd_word = mem[cap_addr];
  end

  // First RESP cycle performs the registered read; later cycles hold until ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_addr   <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      inst_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && req_valid && req_ready) cap_addr <= req_addr;
      if (state == RESP) begin
        if (!inst_valid) begin
          inst       <= rd_word;
          inst_err   <= !in_range(cap_addr);
          inst_valid <= 1'b1;
        end else if (inst_ack) begin
          inst_valid <= 1'b0;
          inst_err   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_server.sv
// Bench for inst_mem_server: two configurations (DEPTH4/WAIT2 and DEPTH3/WAIT0)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_inst_mem_server;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid [2];
  logic [1:0] req_addr  [2];
  logic       req_ready [2];
  logic [7:0] inst      [2];
  logic       inst_valid[2];
  logic       inst_err  [2];
  logic       inst_ack  [2];
  logic       ld_en     [2];
  logic [1:0] ld_addr   [2];
  logic [7:0] ld_data   [2];
  logic       ld_ready  [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_mem_server #(.DATA_W(8), .ADDR_W(2), .DEPTH(4), .WAIT_CYCLES(2), .NOP_WORD(8'h00)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_ready(req_ready[0]),
    .inst(inst[0]), .inst_valid(inst_valid[0]), .inst_err(inst_err[0]), .inst_ack(inst_ack[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0]));

  inst_mem_server #(.DATA_W(8), .ADDR_W(2), .DEPTH(3), .WAIT_CYCLES(0), .NOP_WORD(8'hEE)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_ready(req_ready[1]),
    .inst(inst[1]), .inst_valid(inst_valid[1]), .inst_err(inst_err[1]), .inst_ack(inst_ack[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1]));

  function automatic int dep(input int i);
    return (i == 0) ? 4 : 3;
  endfunction
  function automatic int wc(input int i);
    return (i == 0) ? 2 : 0;
  endfunction
  function automatic logic [7:0] nop(input int i);
    return (i == 0) ? 8'h00 : 8'hEE;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch accepted at edge k presents its word from edge k+WAIT+1
  logic [7:0] m_mem [2][4];
  bit         m_busy[2];
  bit         m_val [2];
  bit         m_err [2];
  logic [7:0] m_inst[2];
  logic [1:0] m_addr[2];
  int         m_cnt [2];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        for (int a = 0; a < 4; a++) m_mem[i][a] = 8'h00;
        m_busy[i] = 0; m_val[i] = 0; m_err[i] = 0; m_inst[i] = 8'h00; m_cnt[i] = 0; m_addr[i] = 2'd0;
      end else if (!m_busy[i]) begin
        if (ld_en[i]) begin
          if (int'(ld_addr[i]) < dep(i)) m_mem[i][ld_addr[i]] = ld_data[i];
        end else if (req_valid[i]) begin
          m_busy[i] = 1; m_addr[i] = req_addr[i]; m_cnt[i] = wc(i) + 1;
        end
      end else if (!m_val[i]) begin
        m_cnt[i]--;
        if (m_cnt[i] == 0) begin
          m_val[i]  = 1;
          m_err[i]  = int'(m_addr[i]) >= dep(i);
          m_inst[i] = m_err[i] ? nop(i) : m_mem[i][m_addr[i]];
        end
      end else if (inst_ack[i]) begin
        m_val[i] = 0; m_err[i] = 0; m_busy[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("inst_valid%0d", i), 32'(inst_valid[i]), 32'(m_val[i]));
      chk($sformatf("inst_err%0d", i),   32'(inst_err[i]),   32'(m_err[i]));
      chk($sformatf("inst%0d", i),       32'(inst[i]),       32'(m_inst[i]));
      chk($sformatf("req_ready%0d", i),  32'(req_ready[i]),  32'(rst && !m_busy[i] && !ld_en[i]));
      chk($sformatf("ld_ready%0d", i),   32'(ld_ready[i]),   32'(rst && !m_busy[i]));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic load_both(input logic [1:0] a, input logic [7:0] d);
    for (int i = 0; i < 2; i++) begin ld_en[i] = 1'b1; ld_addr[i] = a; ld_data[i] = d; end
    tick();
    for (int i = 0; i < 2; i++) ld_en[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (!inst_valid[i] && lat < 20) begin tick(); lat++; end
    if (!inst_valid[i]) chk($sformatf("valid_timeout%0d", i), 32'(inst_valid[i]), 32'd1);
  endtask

  task automatic fetch(input int i, input logic [1:0] a, output int lat);
    int n;
    req_valid[i] = 1'b1; req_addr[i] = a; n = 0;
    #1;
    while (!req_ready[i] && n < 20) begin tick(); #1; n++; end
    if (!req_ready[i]) chk($sformatf("accept_timeout%0d", i), 32'(req_ready[i]), 32'd1);
    tick();
    req_valid[i] = 1'b0;
    wait_valid(i, lat);
  endtask

  task automatic ack(input int i);
    inst_ack[i] = 1'b1;
    tick();
    inst_ack[i] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  acc [2];
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 0; req_addr[i] = 0; inst_ack[i] = 0; ld_en[i] = 0; ld_addr[i] = 0; ld_data[i] = 0;
    end
    repeat (3) tick();
    chk("rst_inst0", 32'(inst[0]), 32'h0);
    chk("rst_valid0", 32'(inst_valid[0]), 32'h0);
    chk("rst_ldready0", 32'(ld_ready[0]), 32'h0);
    #1 rst = 1'b1;
    tick();

    load_both(2'd0, 8'hA1);
    load_both(2'd1, 8'hB2);
    load_both(2'd2, 8'hC3);
    load_both(2'd3, 8'hD4);
    chk("model_mem0_2", 32'(m_mem[0][2]), 32'hC3);
    chk("model_mem1_3_dropped", 32'(m_mem[1][3]), 32'h00);

    fetch(0, 2'd2, lat);
    chk("lat_w2", lat, 3);
    chk("fetch2_inst", 32'(inst[0]), 32'hC3);
    chk("fetch2_err", 32'(inst_err[0]), 32'h0);
    ack(0);

    fetch(0, 2'd1, lat);
    repeat (5) begin
      tick();
      chk("held_inst", 32'(inst[0]), 32'hB2);
      chk("held_valid", 32'(inst_valid[0]), 32'h1);
      chk("held_req_ready", 32'(req_ready[0]), 32'h0);
    end
    ack(0);
    chk("after_ack_ready", 32'(req_ready[0]), 32'h1);
    chk("after_ack_inst_kept", 32'(inst[0]), 32'hB2);

    ld_en[0] = 1'b1; ld_addr[0] = 2'd3; ld_data[0] = 8'h5E;
    req_valid[0] = 1'b1; req_addr[0] = 2'd3;
    #1;
    chk("contend_req_ready", 32'(req_ready[0]), 32'h0);
    chk("contend_ld_ready", 32'(ld_ready[0]), 32'h1);
    tick();
    ld_en[0] = 1'b0;
    fetch(0, 2'd3, lat);
    chk("contend_inst", 32'(inst[0]), 32'h5E);
    ack(0);

    fetch(1, 2'd3, lat);
    chk("lat_w0", lat, 1);
    chk("oor_inst", 32'(inst[1]), 32'hEE);
    chk("oor_err", 32'(inst_err[1]), 32'h1);
    ack(1);
    chk("oor_err_clear", 32'(inst_err[1]), 32'h0);
    ld_en[1] = 1'b1; ld_addr[1] = 2'd3; ld_data[1] = 8'h99;
    tick();
    ld_en[1] = 1'b0;
    fetch(1, 2'd2, lat);
    chk("oor_load_keep2", 32'(inst[1]), 32'hC3);
    ack(1);
    fetch(1, 2'd0, lat);
    chk("oor_load_keep0", 32'(inst[1]), 32'hA1);
    ack(1);

    req_valid[0] = 1'b1; req_addr[0] = 2'd0;
    tick();
    req_valid[0] = 1'b0;
    ld_en[0] = 1'b1; ld_addr[0] = 2'd0; ld_data[0] = 8'h77;
    #1;
    chk("wait_ld_ready", 32'(ld_ready[0]), 32'h0);
    tick();
    ld_en[0] = 1'b0;
    wait_valid(0, lat);
    ack(0);
    fetch(0, 2'd0, lat);
    chk("blocked_load_inst", 32'(inst[0]), 32'hA1);
    ack(0);

    req_valid[0] = 1'b1; req_addr[0] = 2'd1;
    tick();
    req_valid[0] = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(inst_valid[0]), 32'h0);
    chk("arst_inst", 32'(inst[0]), 32'h0);
    chk("arst_req_ready", 32'(req_ready[0]), 32'h0);
    chk("arst_ld_ready", 32'(ld_ready[0]), 32'h0);
    repeat (2) tick();
    #1 rst = 1'b1;
    repeat (5) begin
      tick();
      chk("post_rst_no_valid", 32'(inst_valid[0]), 32'h0);
    end
    fetch(0, 2'd0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_cleared", 32'(inst[0]), 32'h00);
    ack(0);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(req_valid[i] && !acc[i] && c > 0)) begin
          req_valid[i] = ($urandom_range(2) == 0);
          req_addr[i]  = 2'($urandom_range(3));
        end
        ld_en[i]    = ($urandom_range(3) == 0);
        ld_addr[i]  = 2'($urandom_range(3));
        ld_data[i]  = 8'($urandom);
        inst_ack[i] = ($urandom_range(1) == 1);
      end
      if (c == 300) begin
        #1 rst = 1'b0;
        tick();
        #1 rst = 1'b1;
      end
      #1;
      for (int i = 0; i < 2; i++) acc[i] = req_valid[i] && req_ready[i];
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
